multi_digit_watch: RTL and testbench

Parametrised successor to the single-digit watch top: a multi-digit clock/chronometer core with on-chip button conditioning and a time-multiplexed 7-segment display driver. The block keeps a free-running HH:MM:SS watch and an independent MM:SS chronometer. It handles three operating modes (WATCH, CHANGE, CHRONO) and scans NUM_DIGITS common-cathode digits from a single segment bus. It sits directly between the board pins and the display.

---
 rtl/multi_digit_watch.sv | 270 +++++++++++++++++++++++++++
 tb/tb_multi_digit_watch.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/multi_digit_watch.sv
// multi_digit_watch: HH:MM:SS watch plus free-running chronometer with button
// conditioning and a time-multiplexed common-cathode 7-segment driver.
//
// Ports:
//   sys_clk        system clock (single domain)
//   rst_n          asynchronous active-low reset
//   btn_*_in       raw active-high buttons (mode, start, adjust)
//   seg_out        segments a..g on bits 0..6, active-high
//   dig_sel_out    one-hot digit enable, bit0 = rightmost digit
//   status_*       one-hot mode indicators (WATCH, CHANGE, CHRONO)
module multi_digit_watch #(
  parameter int unsigned CLK_HZ          = 27_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 270_000,
  parameter int unsigned SCAN_CYCLES     = 27_000,
  parameter int unsigned NUM_DIGITS      = 4
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic                  btn_mode_in,
  input  logic                  btn_start_in,
  input  logic                  btn_adjust_in,
  output logic [6:0]            seg_out,
  output logic [NUM_DIGITS-1:0] dig_sel_out,
  output logic                  status_watch,
  output logic                  status_change,
  output logic                  status_chrono
);
  localparam int unsigned DivW  = $clog2(CLK_HZ);
  localparam int unsigned DbW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned ScanW = $clog2(SCAN_CYCLES + 1);
  localparam int unsigned IdxW  = $clog2(NUM_DIGITS);

  typedef enum logic [1:0] {StWatch, StChange, StChrono} mode_e;

  function automatic logic [7:0] bcd2(input logic [6:0] v);
    logic [3:0] t, u;
    t = 4'(v / 7'd10);
    u = 4'(v % 7'd10);
    return {t, u};
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b0111111;
      4'd1:    return 7'b0000110;
      4'd2:    return 7'b1011011;
      4'd3:    return 7'b1001111;
      4'd4:    return 7'b1100110;
      4'd5:    return 7'b1101101;
      4'd6:    return 7'b1111101;
      4'd7:    return 7'b0000111;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  // ---------------- button conditioning (bit0 mode, bit1 start, bit2 adjust)
  logic [2:0]     w_btn_raw;
  logic [2:0]     r_sync1, r_sync2, r_stable, r_stable_d, r_press;
  logic [DbW-1:0] r_db_cnt [3];

  assign w_btn_raw = {btn_adjust_in, btn_start_in, btn_mode_in};

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_stable   <= '0;
      r_stable_d <= '0;
      r_press    <= '0;
      for (int i = 0; i < 3; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1    <= w_btn_raw;
      r_sync2    <= r_sync1;
      r_stable_d <= r_stable;
      r_press    <= r_stable & ~r_stable_d;
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DbW'(DEBOUNCE_CYCLES - 1)) begin
          r_stable[i] <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DbW'(1);
        end
      end
    end
  end

  // Same-cycle priority: mode > start > adjust.
  logic w_mode_p, w_start_p, w_adj_p;
  assign w_mode_p  = r_press[0];
  assign w_start_p = r_press[1] & ~r_press[0];
  assign w_adj_p   = r_press[2] & ~|r_press[1:0];

  // ---------------- 1 Hz divider
  logic [DivW-1:0] r_div;
  logic            w_tick, w_blink_off;
  assign w_tick      = (r_div == DivW'(CLK_HZ - 1));
  assign w_blink_off = (r_div < DivW'(CLK_HZ / 2));

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n)      r_div <= '0;
    else if (w_tick) r_div <= '0;
    else             r_div <= r_div + DivW'(1);
  end

  // ---------------- mode FSM with registered status
  mode_e      r_mode;
  logic [2:0] r_status;
  logic       r_sel_min;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode    <= StWatch;
      r_status  <= 3'b001;
      r_sel_min <= 1'b0;
    end else if (w_mode_p) begin
      case (r_mode)
        StWatch: begin
          r_mode    <= StChange;
          r_status  <= 3'b010;
          r_sel_min <= 1'b0;
        end
        StChange: begin
          r_mode   <= StChrono;
          r_status <= 3'b100;
        end
        default: begin
          r_mode   <= StWatch;
          r_status <= 3'b001;
        end
      endcase
    end else if (w_start_p && r_mode == StChange) begin
      r_sel_min <= ~r_sel_min;
    end
  end

  assign status_watch  = r_status[0];
  assign status_change = r_status[1];
  assign status_chrono = r_status[2];

  // ---------------- watch time (r_mode is the pre-press mode, so a tick
  // coinciding with a mode press follows the old freeze rule)
  logic [4:0] r_hh;
  logic [5:0] r_mm, r_ss;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hh <= '0;
      r_mm <= '0;
      r_ss <= '0;
    end else if (r_mode == StChange) begin
      if (w_adj_p) begin
        r_ss <= '0;
        if (r_sel_min) r_mm <= (r_mm == 6'd59) ? 6'd0 : r_mm + 6'd1;
        else           r_hh <= (r_hh == 5'd23) ? 5'd0 : r_hh + 5'd1;
      end
    end else if (w_tick) begin
      if (r_ss == 6'd59) begin
        r_ss <= '0;
        if (r_mm == 6'd59) begin
          r_mm <= '0;
          r_hh <= (r_hh == 5'd23) ? 5'd0 : r_hh + 5'd1;
        end else begin
          r_mm <= r_mm + 6'd1;
        end
      end else begin
        r_ss <= r_ss + 6'd1;
      end
    end
  end

  // ---------------- chronometer (hours field only advances with 6 digits)
  logic       r_ch_run;
  logic [6:0] r_ch_hh;
  logic [5:0] r_ch_mm, r_ch_ss;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ch_run <= 1'b0;
      r_ch_hh  <= '0;
      r_ch_mm  <= '0;
      r_ch_ss  <= '0;
    end else begin
      if (r_mode == StChrono && w_start_p) r_ch_run <= ~r_ch_run;
      if (r_mode == StChrono && w_adj_p && !r_ch_run) begin
        r_ch_hh <= '0;
        r_ch_mm <= '0;
        r_ch_ss <= '0;
      end else if (w_tick && r_ch_run) begin
        if (r_ch_ss == 6'd59) begin
          r_ch_ss <= '0;
          if (r_ch_mm == 6'd59) begin
            r_ch_mm <= '0;
            if (NUM_DIGITS == 6) r_ch_hh <= (r_ch_hh == 7'd99) ? 7'd0 : r_ch_hh + 7'd1;
          end else begin
            r_ch_mm <= r_ch_mm + 6'd1;
          end
        end else begin
          r_ch_ss <= r_ch_ss + 6'd1;
        end
      end
    end
  end

  // ---------------- display source; 4'hF is a blank code
  logic [7:0]  w_f2, w_f1, w_f0;
  logic [23:0] w_digits;

  always_comb begin
    w_f2 = 8'hFF;
    w_f1 = 8'hFF;
    w_f0 = 8'hFF;
    if (r_mode == StChrono) begin
      w_f2 = bcd2(r_ch_hh);
      w_f1 = bcd2({1'b0, r_ch_mm});
      w_f0 = bcd2({1'b0, r_ch_ss});
    end else begin
      w_f2 = bcd2({2'b00, r_hh});
      w_f1 = bcd2({1'b0, r_mm});
      w_f0 = bcd2({1'b0, r_ss});
      if (r_mode == StChange && w_blink_off) begin
        if (r_sel_min) w_f1 = 8'hFF;
        else           w_f2 = 8'hFF;
      end
    end
    if (NUM_DIGITS == 6)         w_digits = {w_f2, w_f1, w_f0};
    else if (r_mode == StChrono) w_digits = {8'hFF, w_f1, w_f0};
    else                         w_digits = {8'hFF, w_f2, w_f1};
  end

  // ---------------- digit scan; outputs registered from the next index so
  // seg_out and dig_sel_out switch together
  logic [ScanW-1:0]      r_scan_cnt;
  logic [IdxW-1:0]       r_idx, w_idx_nxt;
  logic [3:0]            w_cur;
  logic [6:0]            r_seg;
  logic [NUM_DIGITS-1:0] r_dig_sel;

  always_comb begin
    w_idx_nxt = r_idx;
    if (r_scan_cnt == ScanW'(SCAN_CYCLES - 1)) begin
      w_idx_nxt = (r_idx == IdxW'(NUM_DIGITS - 1)) ? '0 : r_idx + IdxW'(1);
    end
    w_cur = 4'hF;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_idx_nxt == IdxW'(i)) w_cur = w_digits[4*i +: 4];
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_cnt <= '0;
      r_idx      <= '0;
      r_seg      <= 7'b0111111;
      r_dig_sel  <= NUM_DIGITS'(1);
    end else begin
      r_scan_cnt <= (r_scan_cnt == ScanW'(SCAN_CYCLES - 1)) ? '0 : r_scan_cnt + ScanW'(1);
      r_idx      <= w_idx_nxt;
      r_seg      <= seg7(w_cur);
      r_dig_sel  <= NUM_DIGITS'(1) << w_idx_nxt;
    end
  end

  assign seg_out     = r_seg;
  assign dig_sel_out = r_dig_sel;

endmodule

// File: tb/tb_multi_digit_watch.sv
`timescale 1ns/1ps
module tb_multi_digit_watch;
  localparam int unsigned ClkHz = 100;
  localparam int BMode = 0, BStart = 1, BAdj = 2;

  logic       sys_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_mode = 1'b0, btn_start = 1'b0, btn_adj = 1'b0;
  logic [6:0] seg;
  logic [3:0] dig_sel;
  logic       st_w, st_c, st_ch;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc;

  multi_digit_watch #(
    .CLK_HZ(ClkHz), .DEBOUNCE_CYCLES(4), .SCAN_CYCLES(2), .NUM_DIGITS(4)
  ) dut (
    .sys_clk      (sys_clk),
    .rst_n        (rst_n),
    .btn_mode_in  (btn_mode),
    .btn_start_in (btn_start),
    .btn_adjust_in(btn_adj),
    .seg_out      (seg),
    .dig_sel_out  (dig_sel),
    .status_watch (st_w),
    .status_change(st_c),
    .status_chrono(st_ch)
  );

  always #5 sys_clk = ~sys_clk;

  // Edges since reset release; equals the expected divider value mod ClkHz.
  always @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] seg2bcd(input logic [6:0] s);
    case (s)
      7'h3F: return 4'd0;
      7'h06: return 4'd1;
      7'h5B: return 4'd2;
      7'h4F: return 4'd3;
      7'h66: return 4'd4;
      7'h6D: return 4'd5;
      7'h7D: return 4'd6;
      7'h07: return 4'd7;
      7'h7F: return 4'd8;
      7'h6F: return 4'd9;
      7'h00: return 4'hF;
      default: return 4'hD;
    endcase
  endfunction

  // One full scan; unseen digits read E, blanked digits read F.
  task automatic read_disp(output logic [15:0] val);
    logic [15:0] v;
    v = 16'hEEEE;
    for (int k = 0; k < 8; k++) begin
      @(negedge sys_clk);
      for (int d = 0; d < 4; d++) begin
        if (dig_sel == 4'(1 << d)) v[4*d +: 4] = seg2bcd(seg);
      end
    end
    val = v;
  endtask

  task automatic goto_phase(input int p);
    @(negedge sys_clk);
    while ((cyc % ClkHz) != p) @(negedge sys_clk);
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) goto_phase(0);
    goto_phase(10);
  endtask

  task automatic set_btn(input int which, input logic v);
    case (which)
      BMode:   btn_mode  = v;
      BStart:  btn_start = v;
      default: btn_adj   = v;
    endcase
  endtask

  task automatic press(input int which, input int hold = 10);
    @(negedge sys_clk);
    set_btn(which, 1'b1);
    repeat (hold) @(negedge sys_clk);
    set_btn(which, 1'b0);
    repeat (10) @(negedge sys_clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] d;

    // Reset state
    repeat (3) @(negedge sys_clk);
    check("rst_seg", seg, 7'h3F);
    check("rst_dig", dig_sel, 4'b0001);
    check("rst_status", {st_ch, st_c, st_w}, 3'b001);
    rst_n = 1'b1;

    // 60 ticks -> 00:01:00, display HH:MM
    wait_ticks(60);
    read_disp(d);
    check("watch_60s", d, 16'h0001);
    check("watch_status", {st_ch, st_c, st_w}, 3'b001);

    // Preload 23:59 in CHANGE, leave, roll over after 60 ticks
    press(BMode);
    check("change_status", {st_ch, st_c, st_w}, 3'b010);
    repeat (23) press(BAdj);
    press(BStart);
    repeat (58) press(BAdj);
    goto_phase(55);
    read_disp(d);
    check("preload", d, 16'h2359);
    goto_phase(10);
    press(BMode);
    check("chrono_status", {st_ch, st_c, st_w}, 3'b100);
    read_disp(d);
    check("chrono_idle", d, 16'h0000);
    press(BMode);
    check("back_watch", {st_ch, st_c, st_w}, 3'b001);
    wait_ticks(59);
    read_disp(d);
    check("pre_rollover", d, 16'h2359);
    wait_ticks(1);
    read_disp(d);
    check("rollover", d, 16'h0000);

    // CHANGE: hours x3, minutes x61 (wraps, no carry), blink, freeze
    press(BMode);
    check("change2_status", {st_ch, st_c, st_w}, 3'b010);
    repeat (3) press(BAdj);
    goto_phase(55);
    read_disp(d);
    check("adj_hours", d, 16'h0300);
    press(BStart);
    repeat (61) press(BAdj);
    goto_phase(15);
    read_disp(d);
    check("blink_minutes", d, 16'h03FF);
    goto_phase(55);
    read_disp(d);
    check("adj_minutes", d, 16'h0301);
    repeat (5) goto_phase(0);
    goto_phase(55);
    read_disp(d);
    check("change_frozen", d, 16'h0301);

    // Chronometer
    press(BMode);
    check("chrono2_status", {st_ch, st_c, st_w}, 3'b100);
    read_disp(d);
    check("chrono_zero", d, 16'h0000);
    goto_phase(10);
    press(BStart);
    wait_ticks(3);
    press(BAdj);
    read_disp(d);
    check("adj_while_run", d, 16'h0003);
    wait_ticks(122);
    press(BStart);
    read_disp(d);
    check("chrono_stop", d, 16'h0205);
    wait_ticks(2);
    read_disp(d);
    check("chrono_held", d, 16'h0205);
    press(BAdj);
    read_disp(d);
    check("chrono_clear", d, 16'h0000);
    goto_phase(10);
    press(BStart);
    press(BMode);
    check("watch3_status", {st_ch, st_c, st_w}, 3'b001);
    wait_ticks(10);
    press(BMode);
    press(BMode);
    check("chrono3_status", {st_ch, st_c, st_w}, 3'b100);
    read_disp(d);
    check("chrono_bg_run", d, 16'h0010);

    // Glitch shorter than debounce, then one real press
    @(negedge sys_clk);
    btn_mode = 1'b1;
    repeat (2) @(negedge sys_clk);
    btn_mode = 1'b0;
    repeat (20) @(negedge sys_clk);
    check("glitch_ignored", {st_ch, st_c, st_w}, 3'b100);
    press(BMode);
    repeat (20) @(negedge sys_clk);
    check("one_transition", {st_ch, st_c, st_w}, 3'b001);

    // Asynchronous reset while chrono runs
    press(BMode);
    press(BMode);
    goto_phase(10);
    press(BStart);
    repeat (150) @(negedge sys_clk);
    for (int k = 0; k < 16; k++) begin
      if (dig_sel == 4'b0100) break;
      @(negedge sys_clk);
    end
    @(posedge sys_clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_seg", seg, 7'h3F);
    check("async_dig", dig_sel, 4'b0001);
    check("async_status", {st_ch, st_c, st_w}, 3'b001);
    repeat (3) @(negedge sys_clk);
    rst_n = 1'b1;
    press(BMode);
    press(BMode);
    read_disp(d);
    check("chrono_after_rst", d, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
